kbd_ascii_tracker: RTL

- Sequential successor to the combinational keyboard ASCII/hex display path.
- Consumes the byte stream from the PS/2 receiver, runs a make/break/extended-prefix FSM, and tracks Shift, Ctrl and Caps Lock.
- Fetches ASCII from an external synchronous scan-code ROM, then applies Caps, Shift-symbol and Ctrl-code rules.
- Keeps a keystroke counter and a history of the last HIST_DEPTH characters, and drives seven-segment digits (active-low) for the current character and the count.

---
 rtl/kbd_pkg.sv | 35 +++
 rtl/kbd_ascii_tracker_shift_symbol_map.sv | 34 +++
 rtl/kbd_ascii_tracker.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
// Shared scan-code constants, FSM state type and seven-segment table for the
// keyboard ASCII tracker.
package kbd_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    typedef enum logic [2:0] {
        ST_IDLE, ST_BRK, ST_EXT, ST_EXT_BRK, ST_REQ, ST_CONV
    } kbd_state_t;

    typedef struct packed {
        logic lshift;
        logic rshift;
        logic lctrl;
        logic rctrl;
        logic caps;
        logic caps_held;
    } mod_state_t;

    // Active-low segments, index 15 first so SEG_TABLE[n] is digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/kbd_ascii_tracker_shift_symbol_map.sv
// Shifted-symbol lookup for non-letter ASCII; unknown codes pass through.
module shift_symbol_map (
    input  logic [7:0] code,
    output logic [7:0] sym
);
    always_comb begin
        sym = code;
        case (code)
            8'h60: sym = 8'h7E;
            8'h31: sym = 8'h21;
            8'h32: sym = 8'h40;
            8'h33: sym = 8'h23;
            8'h34: sym = 8'h24;
            8'h35: sym = 8'h25;
            8'h36: sym = 8'h5E;
            8'h37: sym = 8'h26;
            8'h38: sym = 8'h2A;
            8'h39: sym = 8'h28;
            8'h30: sym = 8'h29;
            8'h2D: sym = 8'h5F;
            8'h3D: sym = 8'h2B;
            8'h5B: sym = 8'h7B;
            8'h5D: sym = 8'h7D;
            8'h5C: sym = 8'h7C;
            8'h3B: sym = 8'h3A;
            8'h27: sym = 8'h22;
            8'h2C: sym = 8'h3C;
            8'h2E: sym = 8'h3E;
            8'h2F: sym = 8'h3F;
            8'h7F: sym = 8'h2E;
            default: sym = code;
        endcase
    end
endmodule

// File: rtl/kbd_ascii_tracker.sv
// PS/2 byte stream -> modifier tracking, ROM-based ASCII conversion,
// keystroke count, character history and seven-segment display.
module kbd_ascii_tracker
    import kbd_pkg::*;
#(
    parameter int CNT_W            = 8,
    parameter int HIST_DEPTH       = 4,
    parameter int REPEAT_EN        = 0,
    parameter int BLANK_ON_RELEASE = 1
) (
    input  logic                    clk,
    input  logic                    clrn,
    input  logic                    code_valid,
    input  logic [7:0]              scan_code,
    output logic [7:0]              rom_addr,
    input  logic [7:0]              rom_lower,
    input  logic [7:0]              rom_upper,
    output logic [7:0]              ascii,
    output logic                    ascii_valid,
    output logic                    key_down,
    output logic                    shift,
    output logic                    ctrl,
    output logic                    caps,
    output logic                    overrun,
    output logic [CNT_W-1:0]        key_count,
    output logic [8*HIST_DEPTH-1:0] hist,
    output logic [13:0]             hex_ascii,
    output logic [13:0]             hex_count
);

    kbd_state_t                     state, state_nxt;
    mod_state_t                     mods;
    logic [7:0]                     cur_key;
    logic                           have_char;
    logic [HIST_DEPTH-1:0][7:0]     hist_r;
    logic                           is_special, is_repeat, is_lower;
    logic                           make_go, byte_drop, conv_fire;
    logic [7:0]                     sym, conv_res;
    logic [7:0]                     cnt8;

    assign shift = mods.lshift | mods.rshift;
    assign ctrl  = mods.lctrl | mods.rctrl;
    assign caps  = mods.caps;
    assign hist  = hist_r;

    assign is_special = scan_code inside {SC_BREAK, SC_EXT, SC_LSHIFT,
                                          SC_RSHIFT, SC_CTRL, SC_CAPS};
    assign is_repeat  = (scan_code == cur_key) && key_down && (REPEAT_EN == 0);
    assign is_lower   = (rom_lower >= 8'h61) && (rom_lower <= 8'h7A);

    shift_symbol_map u_sym (.code(rom_lower), .sym(sym));

    always_comb begin
        if (ctrl && is_lower)
            conv_res = rom_lower & 8'h1F;
        else if (is_lower)
            conv_res = (caps ^ shift) ? rom_upper : rom_lower;
        else if (shift)
            conv_res = sym;
        else
            conv_res = rom_lower;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (code_valid) begin
                if (scan_code == SC_BREAK)    state_nxt = ST_BRK;
                else if (scan_code == SC_EXT) state_nxt = ST_EXT;
                else if (make_go)             state_nxt = ST_REQ;
            end
            ST_BRK, ST_EXT_BRK: if (code_valid) state_nxt = ST_IDLE;
            ST_EXT: if (code_valid)
                state_nxt = (scan_code == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
            ST_REQ:  state_nxt = ST_CONV;
            ST_CONV: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bytes arriving while the ROM read is in flight are lost, not queued.
    always_comb begin
        make_go   = 1'b0;
        byte_drop = 1'b0;
        conv_fire = 1'b0;
        case (state)
            ST_IDLE: make_go = code_valid && !is_special && !is_repeat;
            ST_REQ:  byte_drop = code_valid;
            ST_CONV: begin
                byte_drop = code_valid;
                conv_fire = (conv_res != 8'h00);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mods        <= '0;
            cur_key     <= '0;
            key_down    <= 1'b0;
            rom_addr    <= '0;
            ascii       <= '0;
            ascii_valid <= 1'b0;
            overrun     <= 1'b0;
            key_count   <= '0;
            hist_r      <= '0;
            have_char   <= 1'b0;
        end else begin
            ascii_valid <= 1'b0;
            overrun     <= byte_drop;
            case (state)
                ST_IDLE: if (code_valid) begin
                    case (scan_code)
                        SC_LSHIFT: mods.lshift <= 1'b1;
                        SC_RSHIFT: mods.rshift <= 1'b1;
                        SC_CTRL:   mods.lctrl  <= 1'b1;
                        SC_CAPS: begin
                            if (!mods.caps_held) mods.caps <= !mods.caps;
                            mods.caps_held <= 1'b1;
                        end
                        SC_BREAK, SC_EXT: ;
                        default: begin
                            cur_key <= scan_code;
                            if (make_go) begin
                                rom_addr <= scan_code;
                                key_down <= 1'b1;
                            end
                        end
                    endcase
                end
                ST_BRK: if (code_valid) begin
                    case (scan_code)
                        SC_LSHIFT: mods.lshift    <= 1'b0;
                        SC_RSHIFT: mods.rshift    <= 1'b0;
                        SC_CTRL:   mods.lctrl     <= 1'b0;
                        SC_CAPS:   mods.caps_held <= 1'b0;
                        default: ;
                    endcase
                    if (scan_code == cur_key) key_down <= 1'b0;
                end
                ST_EXT: if (code_valid && scan_code == SC_CTRL) mods.rctrl <= 1'b1;
                ST_EXT_BRK: if (code_valid && scan_code == SC_CTRL) mods.rctrl <= 1'b0;
                ST_CONV: if (conv_fire) begin
                    ascii       <= conv_res;
                    ascii_valid <= 1'b1;
                    key_count   <= key_count + CNT_W'(1);
                    have_char   <= 1'b1;
                    for (int i = HIST_DEPTH-1; i > 0; i--) hist_r[i] <= hist_r[i-1];
                    hist_r[0]   <= conv_res;
                end
                default: ;
            endcase
        end
    end

    assign cnt8      = 8'(key_count);
    assign hex_count = {seg7(cnt8[7:4]), seg7(cnt8[3:0])};
    assign hex_ascii = (!have_char || (BLANK_ON_RELEASE != 0 && !key_down)) ?
                       14'h3FFF : {seg7(ascii[7:4]), seg7(ascii[3:0])};

endmodule
